frame_plotter: RTL and testbench
================================

# frame_plotter

Consumer end of the point-stream interface driven by generated coordinate emitters such as `draw_rectangle`. It accepts signed (x, y) points under a valid/ready handshake and sets the corresponding bit in an internal WIDTH×HEIGHT 1-bpp framebuffer. It keeps plot and clip statistics and exposes a registered pixel read port for benches and display logic. It sits directly downstream of any generator module and replaces per-cycle `$display` scraping as the team's golden capture point.

## Interface
- WIDTH, 64, framebuffer columns (power of two, ≥2)
- HEIGHT, 32, framebuffer rows (power of two, ≥2)
- COUNT_W, 16, width of statistic counters
- _clock  input  1  sole clock, all state on rising edge
- _reset_n  input  1  reset, asynchronous, active-low
- _clear  input  1  single-cycle request to wipe framebuffer and counters
- _in0  input  32  point x, two's-complement signed
- _in1  input  32  point y, two's-complement signed
- _valid  input  1  point on _in0/_in1 is valid
- _ready  output  1  plotter can accept a point this cycle
- _src_done  input  1  level from generator: stream complete
- _rd_x  input  $clog2(WIDTH)  read column
- _rd_y  input  $clog2(HEIGHT)  read row
- _rd_data  output  1  pixel at (_rd_x, _rd_y), one-cycle latency
- _plot_count  output  COUNT_W  in-bounds points accepted
- _clip_count  output  COUNT_W  out-of-bounds points accepted
- _dup_count  output  COUNT_W  accepted points hitting an already-set pixel
- _busy  output  1  high in CLEAR
- _finished  output  1  high in DONE

## Operation
- States: CLEAR, RUN, DONE. Reset enters CLEAR with row counter 0.
- CLEAR: each cycle zeroes one full row (row counter 0..HEIGHT-1). After writing row HEIGHT-1, go to RUN. Counters are held at 0. _ready=0 and _busy=1.
- RUN: _ready=1. Handshake is _valid && _ready at a rising edge. An accepted point with 0≤x<WIDTH and 0≤y<HEIGHT sets bit (x,y) and increments _plot_count. Any other point increments _clip_count and leaves the framebuffer untouched. Comparison is signed on the full 32 bits; no truncation or wrap.
- RUN → DONE when _src_done=1 and _valid=0. If _src_done and _valid are both high, the point is accepted and the block stays in RUN.
- DONE: _ready=0, _finished=1. Framebuffer and counters are frozen. Stays until _clear.
- _clear in any state enters CLEAR with row counter 0, restarting an in-progress clear. If _clear coincides with a handshake, clear wins: the point is neither plotted nor counted.
- Counters saturate at all-ones and never wrap.
- The read port is usable in every state. During CLEAR it returns the partially cleared contents.

## Timing
- Reset values: state CLEAR, row 0, _ready 0, _busy 1, _finished 0, all counters 0, _rd_data 0. Framebuffer contents after reset are defined only once CLEAR completes.
- CLEAR lasts exactly HEIGHT cycles. _ready rises in the cycle after the last row write.
- Read latency is 1: _rd_data in cycle N+1 reflects the address presented at edge N.
- Write-to-read: a point accepted at edge N is visible to a read address sampled at edge N+1, which returns it at N+2. There is no same-edge bypass.
- Counters update at the accepting edge and are visible the following cycle.
- Throughput is one point per cycle in RUN. _ready does not depend combinationally on _valid.
- _reset_n low mid-operation immediately forces the reset values. Deassertion is synchronised by the integrator.

## Configuration
- FRAME_PLOTTER_DUP_COUNT_EN defined: an accepted in-bounds point whose pixel was already 1 increments _dup_count. It still counts in _plot_count.
- Not defined: _dup_count is tied to 0 and the duplicate-detect read path is removed. All other behaviour is identical.

## Test plan
- Reset, then hold idle: _busy high for exactly 32 cycles; _ready rises on cycle 33. Reading (5,5) returns 0.
- Stream the 20 perimeter pixels of a 7×5 rectangle at (23,17), then raise _src_done. Required: _plot_count=20, _finished=1; (23,17)=1, (29,21)=1, (24,18)=0.
- Points (-1,0), (64,3), (0,32), (63,31). Required: _clip_count=3, _plot_count=1, (63,31)=1.
- With FRAME_PLOTTER_DUP_COUNT_EN, send (10,10) three times. Required: _dup_count=2, _plot_count=3. Without the macro, _dup_count=0.
- Send (1,1); assert _clear together with a valid (2,2). Required: CLEAR entered, counters 0, (1,1)=0 and (2,2)=0 after 32 cycles.
- Pull _reset_n low for one cycle mid-CLEAR at row 10. Required: all outputs return to reset values immediately, and the restarted CLEAR takes the full 32 cycles.

Source files
------------

// File: rtl/frame_plotter.sv
// Point-stream sink: plots signed (x,y) points into a 1-bpp framebuffer and keeps plot/clip/dup statistics.
// Define FRAME_PLOTTER_DUP_COUNT_EN to enable counting of points that land on already-set pixels.
module frame_plotter #(
  parameter int WIDTH   = 64,
  parameter int HEIGHT  = 32,
  parameter int COUNT_W = 16
) (
  input  logic                      _clock,
  input  logic                      _reset_n,
  input  logic                      _clear,
  input  logic [31:0]               _in0,
  input  logic [31:0]               _in1,
  input  logic                      _valid,
  output logic                      _ready,
  input  logic                      _src_done,
  input  logic [$clog2(WIDTH)-1:0]  _rd_x,
  input  logic [$clog2(HEIGHT)-1:0] _rd_y,
  output logic                      _rd_data,
  output logic [COUNT_W-1:0]        _plot_count,
  output logic [COUNT_W-1:0]        _clip_count,
  output logic [COUNT_W-1:0]        _dup_count,
  output logic                      _busy,
  output logic                      _finished
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic signed [31:0] W_LIM = 32'(WIDTH);
  localparam logic signed [31:0] H_LIM = 32'(HEIGHT);

  typedef enum logic [1:0] {CLEAR, RUN, DONE} state_t;
  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
  } point_t;

  state_t          state, state_nxt;
  logic [YW-1:0]   row, row_nxt;
  logic [WIDTH-1:0] fb [HEIGHT];
  point_t          pt;
  logic            in_bounds, accept, plot_hit, clip_hit;
  logic [XW-1:0]   xi;
  logic [YW-1:0]   yi;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  assign pt.x = _in0;
  assign pt.y = _in1;
  assign xi   = pt.x[XW-1:0];
  assign yi   = pt.y[YW-1:0];

  // full 32-bit signed bounds test; low bits are only used once the point is known in range
  assign in_bounds = !pt.x[31] && (pt.x < W_LIM) && !pt.y[31] && (pt.y < H_LIM);
  assign accept    = (state == RUN) && _valid && !_clear;
  assign plot_hit  = accept && in_bounds;
  assign clip_hit  = accept && !in_bounds;

  assign _ready    = (state == RUN);
  assign _busy     = (state == CLEAR);
  assign _finished = (state == DONE);

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    case (state)
      CLEAR: begin
        row_nxt = row + YW'(1);
        if (row == YW'(HEIGHT - 1)) state_nxt = RUN;
      end
      RUN:     if (_src_done && !_valid) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = CLEAR;
    endcase
    if (_clear) begin
      state_nxt = CLEAR;
      row_nxt   = '0;
    end
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state <= CLEAR;
      row   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
    end
  end

  // framebuffer has no reset; the CLEAR sweep defines its contents
  always_ff @(posedge _clock) begin
    if (state == CLEAR) fb[row] <= '0;
    else if (plot_hit)  fb[yi][xi] <= 1'b1;
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) _rd_data <= 1'b0;
    else           _rd_data <= fb[_rd_y][_rd_x];
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      _plot_count <= '0;
      _clip_count <= '0;
    end else if (_clear || state == CLEAR) begin
      _plot_count <= '0;
      _clip_count <= '0;
    end else begin
      if (plot_hit) _plot_count <= sat_inc(_plot_count);
      if (clip_hit) _clip_count <= sat_inc(_clip_count);
    end
  end

`ifdef FRAME_PLOTTER_DUP_COUNT_EN
  logic dup_hit;
  assign dup_hit = plot_hit && fb[yi][xi];

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n)                     _dup_count <= '0;
    else if (_clear || state == CLEAR) _dup_count <= '0;
    else if (dup_hit)                  _dup_count <= sat_inc(_dup_count);
  end
`else
  assign _dup_count = '0;
`endif

endmodule

// File: tb/tb_frame_plotter.sv
// Self-checking bench for frame_plotter: pixel/counter model checked every cycle plus directed literal checks.
module tb_frame_plotter;
  localparam int WIDTH = 64, HEIGHT = 32, COUNT_W = 16;
  localparam int CMAX = (1 << COUNT_W) - 1;

  logic clk = 0, rst_n = 0, clr = 0, valid = 0, src_done = 0;
  logic [31:0] in0 = 0, in1 = 0;
  logic [5:0] rd_x = 0;
  logic [4:0] rd_y = 0;
  logic ready, rd_data, busy, finished;
  logic [COUNT_W-1:0] plot_count, clip_count, dup_count;

  int errs = 0, checks = 0;
  bit mon_en = 0;

  frame_plotter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .COUNT_W(COUNT_W)) dut (
    ._clock(clk), ._reset_n(rst_n), ._clear(clr), ._in0(in0), ._in1(in1),
    ._valid(valid), ._ready(ready), ._src_done(src_done), ._rd_x(rd_x), ._rd_y(rd_y),
    ._rd_data(rd_data), ._plot_count(plot_count), ._clip_count(clip_count),
    ._dup_count(dup_count), ._busy(busy), ._finished(finished));

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pixel map indexed by coordinate, count of clear cycles remaining, done flag.
  bit mfb [WIDTH][HEIGHT];
  bit mknown [HEIGHT];
  int clear_left = HEIGHT;
  bit mdone = 0;
  int mplot = 0, mclip = 0, mdup = 0;
  bit rd_exp = 0, rd_known = 1;
  int px, py, crow;

  task automatic model_reset();
    clear_left = HEIGHT; mdone = 0;
    mplot = 0; mclip = 0; mdup = 0;
    rd_exp = 0; rd_known = 1;
    for (int r = 0; r < HEIGHT; r++) mknown[r] = 0;
  endtask

  task automatic model_zero_row(input int r);
    for (int x = 0; x < WIDTH; x++) mfb[x][r] = 0;
    mknown[r] = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      rd_known = mknown[rd_y];
      rd_exp   = mfb[rd_x][rd_y];
      crow     = HEIGHT - clear_left;
      if (clr) begin
        if (clear_left > 0) model_zero_row(crow);
        clear_left = HEIGHT; mdone = 0;
        mplot = 0; mclip = 0; mdup = 0;
      end else if (clear_left > 0) begin
        model_zero_row(crow);
        clear_left--;
      end else if (!mdone) begin
        if (valid) begin
          px = $signed(in0); py = $signed(in1);
          if (px >= 0 && px < WIDTH && py >= 0 && py < HEIGHT) begin
`ifdef FRAME_PLOTTER_DUP_COUNT_EN
            if (mfb[px][py] && mdup < CMAX) mdup++;
`endif
            mfb[px][py] = 1;
            if (mplot < CMAX) mplot++;
          end else if (mclip < CMAX) mclip++;
        end else if (src_done) mdone = 1;
      end
    end
  end

  always @(negedge clk) if (mon_en) begin
    check("ready", ready, (clear_left == 0 && !mdone));
    check("busy", busy, (clear_left > 0));
    check("finished", finished, mdone);
    check("plot_count", plot_count, mplot);
    check("clip_count", clip_count, mclip);
    check("dup_count", dup_count, mdup);
    if (rd_known) check("rd_data", rd_data, rd_exp);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input int x, input int y);
    valid = 1; in0 = x; in1 = y;
    step();
    valid = 0;
  endtask

  task automatic rd(input int x, input int y, input bit exp, input string name);
    rd_x = 6'(x); rd_y = 5'(y);
    step();
    check(name, rd_data, exp);
  endtask

  task automatic do_clear();
    clr = 1; step(); clr = 0; src_done = 0;
    repeat (HEIGHT) step();
    check("clear_done_ready", ready, 1);
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      n++;
      step();
    end
    check(name, n, HEIGHT);
    check({name, "_ready"}, ready, 1);
  endtask

  initial begin
    repeat (3) step();
    mon_en = 1;
    check("rst_busy", busy, 1);
    check("rst_ready", ready, 0);
    check("rst_rd", rd_data, 0);
    rst_n = 1;
    count_busy("busy_cycles");
    rd(5, 5, 0, "rd_5_5");

    // 7x5 rectangle perimeter at (23,17)
    for (int x = 23; x <= 29; x++) begin send(x, 17); send(x, 21); end
    for (int y = 18; y <= 20; y++) begin send(23, y); send(29, y); end
    src_done = 1; step();
    check("rect_plot", plot_count, 20);
    check("rect_finished", finished, 1);
    rd(23, 17, 1, "rd_23_17");
    rd(29, 21, 1, "rd_29_21");
    rd(24, 18, 0, "rd_24_18");

    do_clear();
    send(-1, 0); send(64, 3); send(0, 32); send(63, 31);
    step();
    check("clip_clip", clip_count, 3);
    check("clip_plot", plot_count, 1);
    rd(63, 31, 1, "rd_63_31");

    do_clear();
    send(10, 10); send(10, 10); send(10, 10);
    step();
`ifdef FRAME_PLOTTER_DUP_COUNT_EN
    check("dup_dup", dup_count, 2);
`else
    check("dup_dup", dup_count, 0);
`endif
    check("dup_plot", plot_count, 3);

    do_clear();
    send(1, 1);
    clr = 1; valid = 1; in0 = 2; in1 = 2;
    step();
    clr = 0; valid = 0;
    check("clr_busy", busy, 1);
    check("clr_plot", plot_count, 0);
    check("clr_clip", clip_count, 0);
    repeat (HEIGHT - 1) step();
    rd(1, 1, 0, "rd_1_1");
    rd(2, 2, 0, "rd_2_2");

    // reset pulse mid-clear, after row 31 holds a set pixel
    send(31, 31);
    clr = 1; step(); clr = 0;
    rd_x = 31; rd_y = 31;
    repeat (10) step();
    check("partial_clear_rd", rd_data, 1);
    rst_n = 0; #1;
    check("midrst_busy", busy, 1);
    check("midrst_ready", ready, 0);
    check("midrst_finished", finished, 0);
    check("midrst_rd", rd_data, 0);
    check("midrst_plot", plot_count, 0);
    step();
    rst_n = 1;
    count_busy("restart_busy_cycles");

    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errs);
    $fatal(1);
  end
endmodule
